// File: rtl/eth_tx_scheduler.sv
// Two-requester round-robin transmit scheduler feeding eth_rmii_tx, with inter-frame gap.
// Optional ETH_TX_PAD_EN: zero-pads frames shorter than MIN_LEN bytes.
module eth_tx_scheduler #(
    parameter int LEN_W      = 11,
    parameter int IFG_CYCLES = 48,
    parameter int MIN_LEN    = 60
) (
    input  logic             clk50,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [LEN_W-1:0] len0,
    input  logic [7:0]       data0,
    output logic             done0,
    input  logic             req1,
    input  logic [LEN_W-1:0] len1,
    input  logic [7:0]       data1,
    output logic             done1,
    output logic [1:0]       grant,
    output logic [LEN_W-1:0] tx_addr,
    output logic             tx_packet,
    output logic [7:0]       tx_data,
    input  logic             tx_advance,
    input  logic             tx_busy
);

`ifdef ETH_TX_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif
    localparam int GAP_W = (IFG_CYCLES > 2) ? $clog2(IFG_CYCLES) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DRAIN, ST_GAP} state_t;

    state_t           state_q;
    logic             sel_q;
    logic             rr_last_q;
    logic             packet_q;
    logic             done0_q;
    logic             done1_q;
    logic [1:0]       grant_q;
    logic [LEN_W-1:0] addr_q;
    logic [LEN_W-1:0] last_q;
    logic [LEN_W-1:0] raw_len_q;
    logic [GAP_W-1:0] gap_q;

    logic             win_sel_d;
    logic             arb_ok_d;
    logic [LEN_W-1:0] win_len_d;
    logic [LEN_W-1:0] eff_len_d;

    // A requester whose done is pulsing this cycle is not re-arbitrated, so a
    // rejected zero-length request cannot be rejected twice.
    always_comb begin
        win_sel_d = (req0 && req1) ? ~rr_last_q : req1;
        win_len_d = win_sel_d ? len1 : len0;
        eff_len_d = win_len_d;
        if (PAD_EN && (win_len_d < LEN_W'(MIN_LEN))) begin
            eff_len_d = LEN_W'(MIN_LEN);
        end
        arb_ok_d = (req0 || req1) && !done0_q && !done1_q;
    end

    always_comb begin
        tx_data = sel_q ? data1 : data0;
        if (PAD_EN && (addr_q >= raw_len_q)) begin
            tx_data = 8'h00;
        end
    end

    // Frame geometry is sampled once at grant and held for the whole frame.
    always_ff @(posedge clk50) begin
        if ((state_q == ST_IDLE) && arb_ok_d && (win_len_d != '0)) begin
            last_q    <= eff_len_d - LEN_W'(1);
            raw_len_q <= win_len_d;
        end
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sel_q     <= 1'b0;
            rr_last_q <= 1'b1;
            packet_q  <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            grant_q   <= 2'b00;
            addr_q    <= '0;
            gap_q     <= '0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_ok_d) begin
                        if (win_len_d == '0) begin
                            done0_q   <= ~win_sel_d;
                            done1_q   <= win_sel_d;
                            rr_last_q <= win_sel_d;
                        end else begin
                            sel_q    <= win_sel_d;
                            grant_q  <= win_sel_d ? 2'b10 : 2'b01;
                            addr_q   <= '0;
                            packet_q <= 1'b1;
                            state_q  <= ST_SEND;
                        end
                    end
                end
                ST_SEND: begin
                    if (tx_advance) begin
                        if (addr_q < last_q) begin
                            addr_q <= addr_q + LEN_W'(1);
                        end else begin
                            packet_q <= 1'b0;
                            state_q  <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!tx_busy) begin
                        done0_q   <= ~sel_q;
                        done1_q   <= sel_q;
                        rr_last_q <= sel_q;
                        grant_q   <= 2'b00;
                        gap_q     <= GAP_W'(IFG_CYCLES - 1);
                        state_q   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q - GAP_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign done0     = done0_q;
    assign done1     = done1_q;
    assign grant     = grant_q;
    assign tx_addr   = addr_q;
    assign tx_packet = packet_q;

endmodule
